multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// Sequencing FSM for the multi-cycle MIPS datapath: shared memory, one ALU, IR/A/B/ALUOut/MDR regs.
// Supports R-type (add/sub/and/or/slt), lw, sw, beq, bne, j, addi, andi.
// Drives datapath muxes, register/memory enables and the 3-bit ALU operation.
// Waits on memory through mem_ready, with a per-access timeout.
// PARAMETERS
// MEM_TIMEOUT  15  max cycles waiting on mem_ready per access; 0 = wait forever
// PORTS
// clk            in   1  clock; all state changes on rising edge
// rst            in   1  asynchronous, active-high reset
// opcode         in   6  IR[31:26]; valid from DECODE onward
// func           in   6  IR[5:0]
// equal          in   1  datapath comparator, A==B; sampled in BRANCH
// mem_ready      in   1  memory has completed the current read/write this cycle
// iord           out  1  memory address: 0=PC, 1=ALUOut
// mem_read       out  1  memory read strobe
// mem_write      out  1  memory write strobe
// ir_write       out  1  load IR from memory data
// pc_write       out  1  load PC
// pc_source      out  2  PC input: 00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}
// alu_src_a      out  1  0=PC, 1=A
// alu_src_b      out  2  00=B, 01=const 4, 10=sext(imm), 11=sext(imm)<<2
// alu_operation  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
// reg_dst        out  1  write reg: 0=rt, 1=rd
// mem_to_reg     out  1  write data: 0=ALUOut, 1=MDR
// reg_write      out  1  register file write enable
// instr_done     out  1  high in final cycle of each retired instruction
// illegal        out  1  one-cycle pulse: unsupported opcode/func seen in DECODE
// mem_error      out  1  one-cycle pulse: memory timeout, instruction abandoned
// BEHAVIOUR
// - rst high: state<=FETCH, wait counter<=0; all outputs forced 0 while rst high, asynchronously.
// - Outputs are combinational from state (plus mem_ready/equal/opcode as noted); default all 0.
// - FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, ADD, pc_source=00.
//   ir_write=pc_write=mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
// - DECODE: alu_src_a=0, alu_src_b=11, ADD, so the branch target goes to ALUOut.
//   Next state: R->EXEC_R, lw/sw->MEM_ADDR, addi/andi->EXEC_I, beq/bne->BRANCH, j->JUMP.
//   Any other opcode, or R-type with an unlisted func: illegal=1, next FETCH, no writes.
//   PC is already advanced, so the bad instruction is skipped.
// - EXEC_R: alu_src_a=1, alu_src_b=00, op from func; next WB_ALU.
//   func map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
// - EXEC_I: alu_src_a=1, alu_src_b=10; op ADD for addi, AND for andi; next WB_ALU.
// - WB_ALU: reg_write=1, mem_to_reg=0, reg_dst=(opcode==0), instr_done=1; next FETCH.
// - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD; next MEM_RD for lw, MEM_WR for sw.
// - MEM_RD: iord=1, mem_read=1; hold until mem_ready, then WB_MEM.
// - WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next FETCH.
// - MEM_WR: iord=1, mem_write=1; hold until mem_ready.
//   instr_done=mem_ready; then FETCH.
// - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01, instr_done=1; next FETCH.
//   pc_write = beq ? equal : ~equal.
// - JUMP: pc_source=10, pc_write=1, instr_done=1; next FETCH.
// - Wait counter (8-bit, saturating):
//   - cleared on entry to FETCH/MEM_RD/MEM_WR and whenever mem_ready=1.
//   - increments each cycle in those states while mem_ready=0.
// - Timeout: counter==MEM_TIMEOUT-1 and mem_ready=0 (MEM_TIMEOUT!=0) -> mem_error=1 that cycle.
//   Strobes still asserted that cycle; no ir/pc/reg write; next FETCH; PC unchanged.
// - mem_ready in the same cycle as timeout: the access completes and no error is raised.
// - rst mid-instruction: FETCH on next cycle after release; no partial writes complete.
// TESTING
// - add (op 000000, func 100000), mem_ready=1 in FETCH: FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1, reg_dst=1 in cycle 4.
// - lw, mem_ready low 3 cycles in MEM_RD: MEM_RD held 4 cycles; WB_MEM then mem_to_reg=1, instr_done=1.
// - beq equal=1: pc_write=1, pc_source=01. bne equal=1: pc_write=0. Both take 3 cycles.
// - opcode 111111 in DECODE: illegal=1 for 1 cycle; next FETCH; reg_write/mem_write never 1.
// - MEM_TIMEOUT=15, mem_ready stuck 0 in MEM_WR: mem_error on 15th cycle; FETCH next; no instr_done.
// - rst asserted in MEM_WR: mem_write drops immediately; after release, FETCH with mem_read=1.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle MIPS sequencer and its datapath/memory.
// Latency: none (plain wires). Backpressure: memory stalls the sequencer via mem_ready.
// master = sequencer (drives controls, sees IR fields/comparator/mem_ready);
// slave  = datapath side (drives IR fields, equal, mem_ready; consumes controls).
interface multicycle_controller_if;
   logic [5:0] opcode;         // IR[31:26]
   logic [5:0] func;           // IR[5:0]
   logic       equal;          // A == B from the datapath comparator
   logic       mem_ready;      // memory finished current access this cycle
   logic       iord;           // memory address: 0=PC, 1=ALUOut
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_source;      // 00=ALU, 01=ALUOut, 10=jump target
   logic       alu_src_a;      // 0=PC, 1=A
   logic [1:0] alu_src_b;      // 00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
   logic [2:0] alu_operation;  // 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
   logic       reg_dst;        // 0=rt, 1=rd
   logic       mem_to_reg;     // 0=ALUOut, 1=MDR
   logic       reg_write;
   logic       instr_done;     // final cycle of a retired instruction
   logic       illegal;        // unsupported opcode/func seen in DECODE
   logic       mem_error;      // memory access timed out, instruction dropped

   modport master (
      input  opcode, func, equal, mem_ready,
      output iord, mem_read, mem_write, ir_write, pc_write, pc_source,
             alu_src_a, alu_src_b, alu_operation, reg_dst, mem_to_reg,
             reg_write, instr_done, illegal, mem_error
   );

   modport slave (
      output opcode, func, equal, mem_ready,
      input  iord, mem_read, mem_write, ir_write, pc_write, pc_source,
             alu_src_a, alu_src_b, alu_operation, reg_dst, mem_to_reg,
             reg_write, instr_done, illegal, mem_error
   );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath (R-type, lw, sw, beq, bne, j, addi, andi).
// Latency: 3 (branch/jump), 4 (ALU ops, sw), 5 (lw) cycles plus memory wait cycles.
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ready; MEM_TIMEOUT cycles without it abandons the instruction.
// Ports: clk, rst (async active-high); bus (master modport) carries IR fields, equal,
// mem_ready in and all datapath mux/enable controls plus status pulses out.
// Controls are combinational from state (and mem_ready/equal/opcode), forced to 0 while rst is high.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 15   // max wait cycles per memory access; 0 = wait forever
) (
   input  logic                   clk,
   input  logic                   rst,
   multicycle_controller_if.master bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // The 8-bit counter saturates at 255, so a limit beyond 256 behaves as "wait forever".
   localparam bit         TO_EN   = (MEM_TIMEOUT > 0) && (MEM_TIMEOUT <= 256);
   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
      S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_operation;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       instr_done;
      logic       illegal;
      logic       mem_error;
   } ctl_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       wait_state;
   logic       timeout;
   logic       r_ok;
   logic [2:0] r_op;
   ctl_t       ctl, ctl_out;

   // R-type function decode
   always_comb begin
      r_ok = 1'b1;
      r_op = ALU_ADD;
      case (bus.func)
         6'b100000: r_op = ALU_ADD;
         6'b100010: r_op = ALU_SUB;
         6'b100100: r_op = ALU_AND;
         6'b100101: r_op = ALU_OR;
         6'b101010: r_op = ALU_SLT;
         default:   r_ok = 1'b0;
      endcase
   end

   assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   // A late mem_ready on the last allowed cycle wins over the timeout.
   assign timeout    = TO_EN && wait_state && !bus.mem_ready && (wait_cnt == TO_LAST);

   always_comb begin
      ctl       = '0;
      state_nxt = state;
      case (state)
         S_FETCH: begin
            ctl.mem_read      = 1'b1;
            ctl.alu_src_b     = 2'b01;
            ctl.alu_operation = ALU_ADD;
            ctl.ir_write      = bus.mem_ready;
            ctl.pc_write      = bus.mem_ready;
            if (bus.mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            // Branch target precomputed into ALUOut while the opcode is decoded.
            ctl.alu_src_b     = 2'b11;
            ctl.alu_operation = ALU_ADD;
            case (bus.opcode)
               OP_RTYPE: begin
                  if (r_ok) state_nxt = S_EXEC_R;
                  else begin
                     ctl.illegal = 1'b1;
                     state_nxt   = S_FETCH;
                  end
               end
               OP_LW, OP_SW:     state_nxt = S_MEM_ADDR;
               OP_ADDI, OP_ANDI: state_nxt = S_EXEC_I;
               OP_BEQ, OP_BNE:   state_nxt = S_BRANCH;
               OP_J:             state_nxt = S_JUMP;
               default: begin
                  // PC already points past the bad word, so it is simply skipped.
                  ctl.illegal = 1'b1;
                  state_nxt   = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_src_b     = 2'b00;
            ctl.alu_operation = r_op;
            state_nxt         = S_WB_ALU;
         end
         S_EXEC_I: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_src_b     = 2'b10;
            ctl.alu_operation = (bus.opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
            state_nxt         = S_WB_ALU;
         end
         S_WB_ALU: begin
            ctl.reg_write  = 1'b1;
            ctl.reg_dst    = (bus.opcode == OP_RTYPE);
            ctl.instr_done = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_MEM_ADDR: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_src_b     = 2'b10;
            ctl.alu_operation = ALU_ADD;
            state_nxt         = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            ctl.iord     = 1'b1;
            ctl.mem_read = 1'b1;
            if (bus.mem_ready) state_nxt = S_WB_MEM;
         end
         S_WB_MEM: begin
            ctl.reg_write  = 1'b1;
            ctl.mem_to_reg = 1'b1;
            ctl.instr_done = 1'b1;
            state_nxt      = S_FETCH;
         end
         S_MEM_WR: begin
            ctl.iord       = 1'b1;
            ctl.mem_write  = 1'b1;
            ctl.instr_done = bus.mem_ready;
            if (bus.mem_ready) state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            ctl.alu_src_a     = 1'b1;
            ctl.alu_src_b     = 2'b00;
            ctl.alu_operation = ALU_SUB;
            ctl.pc_source     = 2'b01;
            ctl.pc_write      = (bus.opcode == OP_BEQ) ? bus.equal : !bus.equal;
            ctl.instr_done    = 1'b1;
            state_nxt         = S_FETCH;
         end
         S_JUMP: begin
            ctl.pc_source  = 2'b10;
            ctl.pc_write   = 1'b1;
            ctl.instr_done = 1'b1;
            state_nxt      = S_FETCH;
         end
         default: state_nxt = S_FETCH;
      endcase
      // Strobes stay up in the timeout cycle; writes are already 0 because mem_ready is low.
      if (timeout) begin
         ctl.mem_error = 1'b1;
         state_nxt     = S_FETCH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         // Count only while stalled in the same wait state; any exit, re-entry or ready clears it.
         if (wait_state && !bus.mem_ready && !timeout && (state_nxt == state))
            wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
         else
            wait_cnt <= '0;
      end
   end

   // Reset gates every control asynchronously so no write can leak through.
   assign ctl_out = rst ? '0 : ctl;

   assign bus.iord          = ctl_out.iord;
   assign bus.mem_read      = ctl_out.mem_read;
   assign bus.mem_write     = ctl_out.mem_write;
   assign bus.ir_write      = ctl_out.ir_write;
   assign bus.pc_write      = ctl_out.pc_write;
   assign bus.pc_source     = ctl_out.pc_source;
   assign bus.alu_src_a     = ctl_out.alu_src_a;
   assign bus.alu_src_b     = ctl_out.alu_src_b;
   assign bus.alu_operation = ctl_out.alu_operation;
   assign bus.reg_dst       = ctl_out.reg_dst;
   assign bus.mem_to_reg    = ctl_out.mem_to_reg;
   assign bus.reg_write     = ctl_out.reg_write;
   assign bus.instr_done    = ctl_out.instr_done;
   assign bus.illegal       = ctl_out.illegal;
   assign bus.mem_error     = ctl_out.mem_error;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its
// state sequence and compares the full control vector against hand-written expectations.
module tb_multicycle_controller;

   typedef struct packed {
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_operation;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       instr_done;
      logic       illegal;
      logic       mem_error;
   } ctl_t;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100,
                          OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                          OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

   localparam ctl_t E_ZERO     = '0;
   localparam ctl_t E_FETCH    = '{mem_read:1'b1, alu_src_b:2'b01, alu_operation:3'b010, default:'0};
   localparam ctl_t E_FETCH_W  = '{mem_read:1'b1, ir_write:1'b1, pc_write:1'b1, alu_src_b:2'b01,
                                   alu_operation:3'b010, default:'0};
   localparam ctl_t E_FETCH_TO = '{mem_read:1'b1, alu_src_b:2'b01, alu_operation:3'b010,
                                   mem_error:1'b1, default:'0};
   localparam ctl_t E_DECODE   = '{alu_src_b:2'b11, alu_operation:3'b010, default:'0};
   localparam ctl_t E_DEC_ILL  = '{alu_src_b:2'b11, alu_operation:3'b010, illegal:1'b1, default:'0};
   localparam ctl_t E_EXEC_R   = '{alu_src_a:1'b1, alu_src_b:2'b00, default:'0};
   localparam ctl_t E_WB_R     = '{reg_write:1'b1, reg_dst:1'b1, instr_done:1'b1, default:'0};
   localparam ctl_t E_WB_I     = '{reg_write:1'b1, instr_done:1'b1, default:'0};
   localparam ctl_t E_IMM_ADD  = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_operation:3'b010, default:'0};
   localparam ctl_t E_IMM_AND  = '{alu_src_a:1'b1, alu_src_b:2'b10, alu_operation:3'b000, default:'0};
   localparam ctl_t E_MEM_RD   = '{iord:1'b1, mem_read:1'b1, default:'0};
   localparam ctl_t E_WB_MEM   = '{reg_write:1'b1, mem_to_reg:1'b1, instr_done:1'b1, default:'0};
   localparam ctl_t E_MEM_WR   = '{iord:1'b1, mem_write:1'b1, default:'0};
   localparam ctl_t E_MEM_WR_D = '{iord:1'b1, mem_write:1'b1, instr_done:1'b1, default:'0};
   localparam ctl_t E_MEM_WR_T = '{iord:1'b1, mem_write:1'b1, mem_error:1'b1, default:'0};
   localparam ctl_t E_BR_TAKE  = '{alu_src_a:1'b1, alu_operation:3'b110, pc_source:2'b01,
                                   pc_write:1'b1, instr_done:1'b1, default:'0};
   localparam ctl_t E_BR_NOT   = '{alu_src_a:1'b1, alu_operation:3'b110, pc_source:2'b01,
                                   instr_done:1'b1, default:'0};
   localparam ctl_t E_JUMP     = '{pc_source:2'b10, pc_write:1'b1, instr_done:1'b1, default:'0};

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   multicycle_controller_if bus ();

   multicycle_controller #(.MEM_TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic ctl_t observe();
      return {bus.iord, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_source,
              bus.alu_src_a, bus.alu_src_b, bus.alu_operation, bus.reg_dst, bus.mem_to_reg,
              bus.reg_write, bus.instr_done, bus.illegal, bus.mem_error};
   endfunction

   task automatic chk(input string tag, input ctl_t exp);
      ctl_t act;
      act = observe();
      checks++;
      assert (act === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, act, exp);
      end
   endtask

   // Land 1 time unit after the next rising edge; inputs change there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the current cycle's outputs, then advance one cycle.
   task automatic step(input string tag, input ctl_t exp);
      #1;
      chk(tag, exp);
      tick();
   endtask

   task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input string tag);
      bus.opcode    = op;
      bus.func      = fn;
      bus.mem_ready = 1'b1;
      step(tag, E_FETCH_W);
   endtask

   logic [5:0] fn_tab [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   logic [2:0] op_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

   initial begin
      ctl_t e;
      rst           = 1'b1;
      bus.opcode    = OP_R;
      bus.func      = 6'b100000;
      bus.equal     = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_all_zero", E_ZERO);
      rst = 1'b0;

      // R-type: FETCH, DECODE, EXEC_R, WB_ALU for each supported func
      for (int i = 0; i < 5; i++) begin
         do_fetch(OP_R, fn_tab[i], "r_fetch");
         step("r_decode", E_DECODE);
         e = E_EXEC_R;
         e.alu_operation = op_tab[i];
         step("r_exec", e);
         step("r_wb", E_WB_R);
      end

      // Immediate ALU ops write rt
      do_fetch(OP_ADDI, 6'b000000, "addi_fetch");
      step("addi_decode", E_DECODE);
      step("addi_exec", E_IMM_ADD);
      step("addi_wb", E_WB_I);
      do_fetch(OP_ANDI, 6'b100000, "andi_fetch");
      step("andi_decode", E_DECODE);
      step("andi_exec", E_IMM_AND);
      step("andi_wb", E_WB_I);

      // lw with three stall cycles in MEM_RD
      do_fetch(OP_LW, 6'b000000, "lw_fetch");
      step("lw_decode", E_DECODE);
      step("lw_addr", E_IMM_ADD);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("lw_stall", E_MEM_RD);
      bus.mem_ready = 1'b1;
      step("lw_rd_done", E_MEM_RD);
      step("lw_wb", E_WB_MEM);

      // sw completing immediately
      do_fetch(OP_SW, 6'b000000, "sw_fetch");
      step("sw_decode", E_DECODE);
      step("sw_addr", E_IMM_ADD);
      step("sw_wr_done", E_MEM_WR_D);

      // Branches: three cycles each, pc_write depends on opcode and equal
      bus.equal = 1'b1;
      do_fetch(OP_BEQ, 6'b000000, "beq_fetch");
      step("beq_decode", E_DECODE);
      step("beq_eq1", E_BR_TAKE);
      do_fetch(OP_BNE, 6'b000000, "bne_fetch");
      step("bne_decode", E_DECODE);
      step("bne_eq1", E_BR_NOT);
      bus.equal = 1'b0;
      do_fetch(OP_BEQ, 6'b000000, "beq_fetch");
      step("beq_decode", E_DECODE);
      step("beq_eq0", E_BR_NOT);
      do_fetch(OP_BNE, 6'b000000, "bne_fetch");
      step("bne_decode", E_DECODE);
      step("bne_eq0", E_BR_TAKE);

      do_fetch(OP_J, 6'b000000, "j_fetch");
      step("j_decode", E_DECODE);
      step("j_jump", E_JUMP);

      // Illegal opcode and illegal R-type func: one-cycle pulse, back to FETCH
      do_fetch(OP_BAD, 6'b000000, "bad_fetch");
      step("bad_op_decode", E_DEC_ILL);
      do_fetch(OP_R, 6'b000000, "bad_fn_fetch");
      step("bad_fn_decode", E_DEC_ILL);

      // FETCH stall then complete
      bus.mem_ready = 1'b0;
      step("fetch_stall", E_FETCH);
      step("fetch_stall", E_FETCH);

      // sw with memory stuck: error on the 15th cycle, no instr_done
      do_fetch(OP_SW, 6'b000000, "swto_fetch");
      step("swto_decode", E_DECODE);
      step("swto_addr", E_IMM_ADD);
      bus.mem_ready = 1'b0;
      for (int i = 1; i <= 14; i++) step("swto_wait", E_MEM_WR);
      step("swto_error", E_MEM_WR_T);
      step("swto_refetch", E_FETCH);

      // lw with mem_ready arriving on the 15th cycle: completes, no error
      do_fetch(OP_LW, 6'b000000, "lwlate_fetch");
      step("lwlate_decode", E_DECODE);
      step("lwlate_addr", E_IMM_ADD);
      bus.mem_ready = 1'b0;
      for (int i = 1; i <= 14; i++) step("lwlate_wait", E_MEM_RD);
      bus.mem_ready = 1'b1;
      step("lwlate_ready", E_MEM_RD);
      step("lwlate_wb", E_WB_MEM);

      // FETCH timeout, then the counter restarts
      bus.mem_ready = 1'b0;
      for (int i = 1; i <= 14; i++) step("fetchto_wait", E_FETCH);
      step("fetchto_error", E_FETCH_TO);
      step("fetchto_restart", E_FETCH);

      // Reset in MEM_WR: controls drop at once, FETCH after release
      do_fetch(OP_SW, 6'b000000, "swrst_fetch");
      step("swrst_decode", E_DECODE);
      step("swrst_addr", E_IMM_ADD);
      bus.mem_ready = 1'b0;
      #1;
      chk("swrst_in_wr", E_MEM_WR);
      rst = 1'b1;
      #1;
      chk("swrst_async_zero", E_ZERO);
      tick();
      rst = 1'b0;
      step("swrst_fetch_after", E_FETCH);
      do_fetch(OP_R, 6'b100000, "post_rst_fetch");
      step("post_rst_decode", E_DECODE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
